// File: rtl/register_dispatch_scheduler_if.sv
// Task request channel between the issue front-end and the dispatch scheduler.
// The master offers a task; the slave answers with ready and a reject pulse.
interface register_dispatch_scheduler_if #(
    parameter int REGISTER_AMOUNT = 32,
    parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
);
    logic                       task_valid;
    logic                       task_ready;
    logic [REG_CTN_WIDTH-1:0]   task_dest;
    logic [REGISTER_AMOUNT-1:0] task_src_mask;
    logic                       task_error;

    modport master (
        output task_valid,
        output task_dest,
        output task_src_mask,
        input  task_ready,
        input  task_error
    );

    modport slave (
        input  task_valid,
        input  task_dest,
        input  task_src_mask,
        output task_ready,
        output task_error
    );
endinterface

// File: rtl/register_dispatch_scheduler.sv
// Hazard-checked round-robin issue of register renew tasks to two processors,
// with per-processor launch watchdogs and a drain/quiesce operation.
module register_dispatch_scheduler #(
    parameter int REGISTER_AMOUNT = 32,
    parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT),
    parameter int LAUNCH_TIMEOUT  = 64,
    parameter int TO_CNT_WIDTH    = $clog2(LAUNCH_TIMEOUT + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    register_dispatch_scheduler_if.slave task_bus,
    input  logic                       processor_idle_1,
    input  logic                       processor_idle_2,
    input  logic [REGISTER_AMOUNT-1:0] processing_register_table,
    input  logic                       synchronized_processors,
    output logic                       boot_renew_register_1,
    output logic                       boot_renew_register_2,
    output logic [REG_CTN_WIDTH-1:0]   register_num,
    output logic                       start_processor_1,
    output logic                       start_processor_2,
    input  logic                       drain_req,
    output logic                       drain_done,
    output logic [1:0]                 launch_timeout
);
    typedef enum logic [1:0] {FREE, LAUNCHED, RUNNING} trk_e;

    localparam logic [REGISTER_AMOUNT-1:0] ONE = REGISTER_AMOUNT'(1);
    localparam logic [TO_CNT_WIDTH-1:0] TO_MAX = TO_CNT_WIDTH'(LAUNCH_TIMEOUT);

    trk_e                     state_q [2];
    trk_e                     state_d [2];
    logic [TO_CNT_WIDTH-1:0]  cnt_q   [2];
    logic [TO_CNT_WIDTH-1:0]  cnt_d   [2];
    logic [REG_CTN_WIDTH-1:0] dest_q  [2];
    logic [REG_CTN_WIDTH-1:0] dest_d  [2];

    logic [1:0] idle, free, boot_q, boot_d, to_q, to_d;
    logic       rr_q, rr_d, sel;
    logic       err_q, err_d, done_q, done_d, dpend_q, dpend_d;
    logic [REG_CTN_WIDTH-1:0]   num_q, num_d;
    logic [REGISTER_AMOUNT-1:0] pending, dest_hot;
    logic       reject, hazard, ready, accept, issue, quiesced;

    assign idle     = {processor_idle_2, processor_idle_1};
    assign dest_hot = ONE << task_bus.task_dest;
    assign reject   = (task_bus.task_dest == REG_CTN_WIDTH'(1)) ||
                      (32'(task_bus.task_dest) >= 32'(REGISTER_AMOUNT));

    always_comb begin
        pending = '0;
        for (int n = 0; n < 2; n++) begin
            free[n] = (state_q[n] == FREE);
            if (!free[n]) pending = pending | (ONE << dest_q[n]);
        end
    end

    // Own pending masks bridge the cycle before the table shows the issue
    assign hazard = |((processing_register_table | pending) &
                      (task_bus.task_src_mask | dest_hot));
    assign ready  = !dpend_q && (reject || (!hazard && |free));
    assign accept = task_bus.task_valid && ready;
    assign issue  = accept && !reject;
    assign sel    = (free[0] && free[1]) ? rr_q : ~free[0];
    assign quiesced = &free && (processing_register_table == '0) &&
                      synchronized_processors;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            dest_d[n]  = dest_q[n];
            to_d[n]    = to_q[n];
            boot_d[n]  = issue && (sel == 1'(n));
            if (boot_d[n]) begin
                state_d[n] = LAUNCHED;
                cnt_d[n]   = '0;
                dest_d[n]  = task_bus.task_dest;
            end else begin
                unique case (state_q[n])
                    LAUNCHED: begin
                        if (!idle[n]) begin
                            state_d[n] = RUNNING;
                        end else begin
                            if (cnt_q[n] != TO_MAX)
                                cnt_d[n] = cnt_q[n] + TO_CNT_WIDTH'(1);
                            to_d[n] = to_q[n] | (cnt_d[n] == TO_MAX);
                        end
                    end
                    RUNNING: if (idle[n]) state_d[n] = FREE;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rr_d    = issue ? ~sel : rr_q;
        num_d   = issue ? task_bus.task_dest : num_q;
        err_d   = accept && reject;
        dpend_d = dpend_q;
        done_d  = 1'b0;
        if (dpend_q) begin
            if (quiesced) begin
                dpend_d = 1'b0;
                done_d  = 1'b1;
            end
        end else if (drain_req) begin
            dpend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= FREE;
                cnt_q[n]   <= '0;
                dest_q[n]  <= '0;
            end
            boot_q  <= '0;
            to_q    <= '0;
            rr_q    <= 1'b0;
            num_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            dpend_q <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
                dest_q[n]  <= dest_d[n];
            end
            boot_q  <= boot_d;
            to_q    <= to_d;
            rr_q    <= rr_d;
            num_q   <= num_d;
            err_q   <= err_d;
            done_q  <= done_d;
            dpend_q <= dpend_d;
        end
    end

    assign task_bus.task_ready  = ready;
    assign task_bus.task_error  = err_q;
    assign boot_renew_register_1 = boot_q[0];
    assign boot_renew_register_2 = boot_q[1];
    assign start_processor_1     = boot_q[0];
    assign start_processor_2     = boot_q[1];
    assign register_num          = num_q;
    assign drain_done            = done_q;
    assign launch_timeout        = to_q;
endmodule

// File: tb/tb_register_dispatch_scheduler.sv
// Scoreboard bench: a task-level model predicts ready/pulses, a monitor
// pops expected pulses as the scheduler produces them.
module tb_register_dispatch_scheduler;
    logic        clk;
    logic        rst_n;
    logic        processor_idle_1, processor_idle_2;
    logic [31:0] processing_register_table;
    logic        synchronized_processors;
    logic        boot_renew_register_1, boot_renew_register_2;
    logic [4:0]  register_num;
    logic        start_processor_1, start_processor_2;
    logic        drain_req, drain_done;
    logic [1:0]  launch_timeout;

    register_dispatch_scheduler_if #(.REGISTER_AMOUNT(32)) bus ();

    register_dispatch_scheduler dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .task_bus                  (bus),
        .processor_idle_1          (processor_idle_1),
        .processor_idle_2          (processor_idle_2),
        .processing_register_table (processing_register_table),
        .synchronized_processors   (synchronized_processors),
        .boot_renew_register_1     (boot_renew_register_1),
        .boot_renew_register_2     (boot_renew_register_2),
        .register_num              (register_num),
        .start_processor_1         (start_processor_1),
        .start_processor_2         (start_processor_2),
        .drain_req                 (drain_req),
        .drain_done                (drain_done),
        .launch_timeout            (launch_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // kind: 0 boot, 1 reject, 2 drain done
    typedef struct {
        int due;
        int kind;
        int proc;
        int dest;
    } ev_t;
    ev_t sb[$];

    bit         busy [2];
    bit         started [2];
    int         bdest [2];
    int         lcnt [2];
    int         rr;
    bit         dpend;
    logic [1:0] exp_to;
    logic [4:0] last_dest;
    int         issued_n, issued_dest;

    bit auto_proc;
    int pphase [2];
    int pw [2];
    int pr [2];
    int pdest [2];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int n = 0; n < 2; n++) begin
            busy[n] = 0; started[n] = 0; bdest[n] = 0; lcnt[n] = 0;
            pphase[n] = 0; pw[n] = 0; pr[n] = 0; pdest[n] = 0;
        end
        rr = 0; dpend = 0; exp_to = 2'b00; last_dest = 5'd0;
        issued_n = -1; issued_dest = 0;
    endfunction

    task automatic model_edge();
        logic [31:0] pend, hot, tbl;
        bit rej, haz, rdy, acc, quiet, fr0, fr1;
        bit idl [2];
        int sel, d;
        tbl  = processing_register_table;
        pend = '0;
        for (int n = 0; n < 2; n++) if (busy[n]) pend[bdest[n]] = 1'b1;
        d = int'(bus.task_dest);
        hot = '0;
        hot[d] = 1'b1;
        rej = (d == 1) || (d >= 32);
        haz = ((tbl | pend) & (bus.task_src_mask | hot)) != 0;
        fr0 = !busy[0];
        fr1 = !busy[1];
        rdy = !dpend && (rej || (!haz && (fr0 || fr1)));
        chk("task_ready", bus.task_ready, rdy);
        chk("register_num_hold", register_num, last_dest);
        chk("launch_timeout", launch_timeout, exp_to);
        acc   = bus.task_valid && rdy;
        quiet = fr0 && fr1 && (tbl == 0) && synchronized_processors;
        sel   = (fr0 && fr1) ? rr : (fr0 ? 0 : 1);
        idl[0] = processor_idle_1;
        idl[1] = processor_idle_2;
        for (int n = 0; n < 2; n++) begin
            if (busy[n]) begin
                if (!started[n]) begin
                    if (!idl[n]) started[n] = 1;
                    else begin
                        lcnt[n]++;
                        if (lcnt[n] >= 64) exp_to[n] = 1'b1;
                    end
                end else if (idl[n]) begin
                    busy[n] = 0;
                end
            end
        end
        issued_n = -1;
        if (acc && rej) begin
            sb.push_back('{cyc + 1, 1, 0, 0});
        end else if (acc) begin
            sb.push_back('{cyc + 1, 0, sel, d});
            busy[sel] = 1; started[sel] = 0; lcnt[sel] = 0; bdest[sel] = d;
            rr = 1 - sel;
            last_dest = bus.task_dest;
            issued_n = sel;
            issued_dest = d;
        end
        if (dpend) begin
            if (quiet) begin
                sb.push_back('{cyc + 1, 2, 0, 0});
                dpend = 0;
            end
        end else if (drain_req) begin
            dpend = 1;
        end
    endtask

    // Two toy processors and the register table they update
    task automatic emulate();
        for (int n = 0; n < 2; n++) begin
            case (pphase[n])
                1: if (pw[n] == 0) begin
                       if (n == 0) processor_idle_1 = 1'b0;
                       else processor_idle_2 = 1'b0;
                       pphase[n] = 2;
                   end else pw[n]--;
                2: if (pr[n] == 0) begin
                       if (n == 0) processor_idle_1 = 1'b1;
                       else processor_idle_2 = 1'b1;
                       pphase[n] = 3;
                   end else pr[n]--;
                3: begin
                       processing_register_table[pdest[n]] = 1'b0;
                       pphase[n] = 0;
                   end
                default: ;
            endcase
        end
        if (issued_n >= 0) begin
            pphase[issued_n] = 1;
            pw[issued_n] = $urandom_range(0, 3);
            pr[issued_n] = $urandom_range(0, 5);
            pdest[issued_n] = issued_dest;
            processing_register_table[issued_dest] = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
        if (auto_proc) emulate();
    endtask

    task automatic idle_inputs();
        bus.task_valid = 1'b0;
        bus.task_dest = 5'd0;
        bus.task_src_mask = '0;
        drain_req = 1'b0;
        synchronized_processors = 1'b1;
        processor_idle_1 = 1'b1;
        processor_idle_2 = 1'b1;
        processing_register_table = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        idle_inputs();
        @(negedge clk);
        chk("rst_boot", {boot_renew_register_2, boot_renew_register_1}, 0);
        chk("rst_start", {start_processor_2, start_processor_1}, 0);
        chk("rst_misc", {bus.task_error, drain_done, register_num}, 0);
        chk("rst_timeout", launch_timeout, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic issue(input int dest, input logic [31:0] src);
        bus.task_valid = 1'b1;
        bus.task_dest = 5'(dest);
        bus.task_src_mask = src;
        step();
        bus.task_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        bit eb1, eb2, ee, ed;
        int erd;
        ev_t it;
        if (rst_n) begin
            eb1 = 0; eb2 = 0; ee = 0; ed = 0; erd = -1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                it = sb.pop_front();
                case (it.kind)
                    0: begin
                        if (it.proc == 0) eb1 = 1; else eb2 = 1;
                        erd = it.dest;
                    end
                    1: ee = 1;
                    default: ed = 1;
                endcase
            end
            if (eb1 || eb2 || ee || ed || boot_renew_register_1 ||
                boot_renew_register_2 || start_processor_1 ||
                start_processor_2 || bus.task_error || drain_done) begin
                chk("boot_1", boot_renew_register_1, eb1);
                chk("boot_2", boot_renew_register_2, eb2);
                chk("start_1", start_processor_1, eb1);
                chk("start_2", start_processor_2, eb2);
                chk("task_error", bus.task_error, ee);
                chk("drain_done", drain_done, ed);
                if (erd >= 0) chk("register_num_boot", register_num, erd);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        auto_proc = 1'b1;
        model_reset();
        idle_inputs();
        #2;

        // single task to processor 1
        do_reset();
        issue(5, 32'h4);
        chk("t1_boot1", boot_renew_register_1, 1);
        chk("t1_regnum", register_num, 5);
        repeat (14) step();

        // back-to-back tasks alternate processors
        do_reset();
        issue(5, 32'h0);
        chk("t2_boot1", boot_renew_register_1, 1);
        issue(6, 32'h0);
        chk("t2_boot2", boot_renew_register_2, 1);
        chk("t2_regnum", register_num, 6);
        repeat (14) step();

        // hazard on in-flight dest 7
        do_reset();
        auto_proc = 1'b0;
        issue(7, 32'h0);
        bus.task_valid = 1'b1;
        bus.task_dest = 5'd8;
        bus.task_src_mask = 32'h80;
        processing_register_table = 32'h80;
        repeat (2) step();
        processor_idle_1 = 1'b0;
        repeat (3) step();
        chk("t3_stall", bus.task_ready, 0);
        processor_idle_1 = 1'b1;
        step();
        processing_register_table = '0;
        step();
        bus.task_valid = 1'b0;
        chk("t3_boot2", boot_renew_register_2, 1);
        chk("t3_regnum", register_num, 8);
        repeat (3) step();

        // reject leaves the pointer alone
        do_reset();
        auto_proc = 1'b1;
        issue(1, 32'h0);
        chk("t4_error", bus.task_error, 1);
        issue(3, 32'h0);
        chk("t4_boot1", boot_renew_register_1, 1);
        chk("t4_regnum", register_num, 3);
        repeat (14) step();

        // launch timeout, sticky until reset
        do_reset();
        auto_proc = 1'b0;
        issue(4, 32'h0);
        repeat (62) step();
        chk("t5_before", launch_timeout, 2'b00);
        repeat (6) step();
        chk("t5_after", launch_timeout, 2'b01);
        repeat (5) step();

        // reset cuts an in-flight boot pulse
        do_reset();
        issue(9, 32'h0);
        do_reset();

        // drain while processor 2 runs
        issue(9, 32'h0);
        issue(10, 32'h0);
        processing_register_table = 32'h400;
        processor_idle_1 = 1'b0;
        step();
        processor_idle_2 = 1'b0;
        step();
        processor_idle_1 = 1'b1;
        step();
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        bus.task_valid = 1'b1;
        bus.task_dest = 5'd11;
        bus.task_src_mask = '0;
        step();
        chk("t6_blocked", bus.task_ready, 0);
        repeat (2) step();
        processor_idle_2 = 1'b1;
        step();
        processing_register_table = '0;
        step();
        chk("t6_done", drain_done, 1);
        step();
        chk("t6_boot1", boot_renew_register_1, 1);
        chk("t6_regnum", register_num, 11);
        bus.task_valid = 1'b0;
        repeat (3) step();

        // randomized traffic
        do_reset();
        auto_proc = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.task_valid = ($urandom_range(0, 9) < 6);
            bus.task_dest = ($urandom_range(0, 9) == 0) ? 5'd1 :
                            5'($urandom_range(0, 31));
            bus.task_src_mask = $urandom & $urandom & $urandom & $urandom;
            drain_req = ($urandom_range(0, 99) < 3);
            synchronized_processors = ($urandom_range(0, 9) != 0);
            step();
        end
        bus.task_valid = 1'b0;
        drain_req = 1'b0;
        synchronized_processors = 1'b1;
        repeat (30) step();
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
